// File: rtl/wb_interconnect.sv
// Single-master Wishbone interconnect: address decode to NUM_SLAVES ports, error/timeout handling.
// Optional slave timeout enabled by defining macro WB_IC_TIMEOUT_EN.
module wb_interconnect #(
  parameter int                        NUM_SLAVES     = 3,
  parameter logic [32*NUM_SLAVES-1:0] SLV_BASE       = {32'h9000_2000, 32'h9000_1000, 32'h9000_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLV_MASK       = {3{32'hFFFF_F000}},
  parameter int                        TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic [31:0]                m_adr,
  input  logic [31:0]                m_wdat,
  input  logic                       m_we,
  input  logic [3:0]                 m_sel,
  input  logic                       m_stb,
  input  logic                       m_cyc,
  output logic [31:0]                m_rdat,
  output logic                       m_ack,
  output logic                       m_err,
  output logic [31:0]                s_adr,
  output logic [31:0]                s_wdat,
  output logic                       s_we,
  output logic [3:0]                 s_sel,
  output logic [NUM_SLAVES-1:0]      s_stb,
  output logic [NUM_SLAVES-1:0]      s_cyc,
  input  logic [32*NUM_SLAVES-1:0]   s_rdat,
  input  logic [NUM_SLAVES-1:0]      s_ack,
  input  logic [NUM_SLAVES-1:0]      s_err,
  output logic [31:0]                err_addr,
  output logic [7:0]                 err_count
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
    $error("wb_interconnect: NUM_SLAVES or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] hit_idx;
  logic             hit;
  logic             sel_ack;
  logic             sel_err;
  logic             timeout_hit;
  logic             go_err;
  logic [31:0]      sel_rdat;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Lowest index wins: scan downward so the last assignment is the smallest match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_adr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign sel_ack  = s_ack[sel_idx];
  assign sel_err  = s_err[sel_idx];
  assign sel_rdat = s_rdat[32*sel_idx +: 32];

`ifdef WB_IC_TIMEOUT_EN
  logic [15:0] to_cnt;
  assign timeout_hit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // An ack in the final allowed cycle beats the timeout; a slave error beats the ack.
  assign go_err = sel_err || (!sel_ack && timeout_hit);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      sel_idx   <= '0;
      m_rdat    <= '0;
      m_ack     <= 1'b0;
      m_err     <= 1'b0;
      s_adr     <= '0;
      s_wdat    <= '0;
      s_we      <= 1'b0;
      s_sel     <= '0;
      s_stb     <= '0;
      s_cyc     <= '0;
      err_addr  <= '0;
      err_count <= '0;
`ifdef WB_IC_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m_cyc && m_stb) begin
            if (hit) begin
              s_adr   <= m_adr;
              s_wdat  <= m_wdat;
              s_we    <= m_we;
              s_sel   <= m_sel;
              sel_idx <= hit_idx;
              s_stb   <= NUM_SLAVES'(1) << hit_idx;
              s_cyc   <= NUM_SLAVES'(1) << hit_idx;
`ifdef WB_IC_TIMEOUT_EN
              to_cnt  <= '0;
`endif
              state   <= ACTIVE;
            end else begin
              err_addr  <= m_adr;
              err_count <= sat_inc(err_count);
              m_err     <= 1'b1;
              state     <= RESP;
            end
          end
        end
        ACTIVE: begin
          if (!m_cyc) begin
            s_stb <= '0;
            s_cyc <= '0;
            state <= IDLE;
          end else if (go_err) begin
            s_stb     <= '0;
            s_cyc     <= '0;
            err_addr  <= s_adr;
            err_count <= sat_inc(err_count);
            m_err     <= 1'b1;
            state     <= RESP;
          end else if (sel_ack) begin
            s_stb <= '0;
            s_cyc <= '0;
            if (!s_we) m_rdat <= sel_rdat;
            m_ack <= 1'b1;
            state <= RESP;
          end
`ifdef WB_IC_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Scoreboard bench for wb_interconnect: stimulus pushes expected strobes/responses, a monitor pops and compares.
module tb_wb_interconnect;

  localparam int TO = 4;
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_ABORT = 3, K_RST = 4, K_HANG = 5;

  logic        clk = 1'b0;
  logic        arstn;
  logic [31:0] m_adr, m_wdat, m_rdat;
  logic        m_we, m_stb, m_cyc, m_ack, m_err;
  logic [3:0]  m_sel;
  logic [31:0] s_adr, s_wdat;
  logic        s_we;
  logic [3:0]  s_sel;
  logic [2:0]  s_stb, s_cyc, s_ack, s_err;
  logic [95:0] s_rdat;
  logic [31:0] err_addr;
  logic [7:0]  err_count;

  wb_interconnect #(
    .NUM_SLAVES    (3),
    .SLV_BASE      ({32'h9000_0000, 32'h9000_1000, 32'h9000_0000}),
    .SLV_MASK      ({32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000}),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .arstn(arstn),
    .m_adr(m_adr), .m_wdat(m_wdat), .m_we(m_we), .m_sel(m_sel), .m_stb(m_stb), .m_cyc(m_cyc),
    .m_rdat(m_rdat), .m_ack(m_ack), .m_err(m_err),
    .s_adr(s_adr), .s_wdat(s_wdat), .s_we(s_we), .s_sel(s_sel), .s_stb(s_stb), .s_cyc(s_cyc),
    .s_rdat(s_rdat), .s_ack(s_ack), .s_err(s_err),
    .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_err;
    logic [31:0] rdat;
    logic [31:0] eaddr;
    logic [7:0]  ecnt;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  oh;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [3:0]  sel;
  } stb_t;

  resp_t rq[$];
  stb_t  sq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic [2:0]  prev_stb = '0;
  logic [31:0] exp_rdat = '0;
  logic [31:0] exp_eaddr = '0;
  logic [7:0]  exp_ecnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Address map as seen by the bench: slave 2 covers the whole 0x9000_xxxx page
  // but slaves 0 and 1 take precedence on their own 4 KiB windows.
  function automatic int ref_decode(input logic [31:0] a);
    if (a[31:12] == 20'h90000) return 0;
    if (a[31:12] == 20'h90001) return 1;
    if (a[31:16] == 16'h9000)  return 2;
    return -1;
  endfunction

  function automatic logic [7:0] ref_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (m_ack || m_err) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: m_ack=%0b m_err=%0b with nothing expected (cycle %0d)", m_ack, m_err, cyc);
      end else begin
        resp_t e;
        e = rq.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        chk("resp_kind", {30'd0, m_err, m_ack}, e.is_err ? 32'd2 : 32'd1);
        chk("resp_rdat", m_rdat, e.rdat);
        chk("resp_err_addr", err_addr, e.eaddr);
        chk("resp_err_count", 32'(err_count), 32'(e.ecnt));
        chk("resp_stb_clear", {26'd0, s_stb, s_cyc}, 32'd0);
      end
    end
    if (s_stb != 3'b000 && prev_stb == 3'b000) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_stb: s_stb=%03b with nothing expected (cycle %0d)", s_stb, cyc);
      end else begin
        stb_t e;
        e = sq.pop_front();
        chk("stb_cycle", 32'(cyc), 32'(e.cyc));
        chk("stb_onehot", 32'(s_stb), 32'(e.oh));
        chk("cyc_onehot", 32'(s_cyc), 32'(e.oh));
        chk("s_adr", s_adr, e.adr);
        chk("s_wdat", s_wdat, e.wdat);
        chk("s_we_sel", {27'd0, s_we, s_sel}, {27'd0, e.we, e.sel});
      end
    end
    prev_stb = s_stb;
  end

  task automatic wait_resp();
    for (int n = 0; n < 20; n++) begin
      if (m_ack || m_err) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL resp_wait: no m_ack/m_err within 20 cycles (cycle %0d)", cyc);
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    m_cyc = 1'b0;
    m_stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drive_noise(input logic [2:0] oh, input bit noise);
    s_ack = noise ? ~oh : 3'b000;
    s_err = noise ? ~oh : 3'b000;
  endtask

  // Called at posedge+1 with the DUT idle and the master released.
  task automatic do_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                        input logic [3:0] sel, input int kind, input int k, input bit noise);
    int          idx;
    int          t0;
    logic [2:0]  oh;
    logic [31:0] rd;
    resp_t       r;
    stb_t        s;
    t0 = cyc;
    m_adr = adr; m_we = we; m_wdat = wdat; m_sel = sel;
    m_cyc = 1'b1; m_stb = 1'b1;
    idx = ref_decode(adr);
    if (idx < 0) begin
      exp_eaddr = adr;
      exp_ecnt  = ref_inc(exp_ecnt);
      r = '{t0 + 1, 1'b1, exp_rdat, exp_eaddr, exp_ecnt};
      rq.push_back(r);
      wait_resp();
      end_req();
      return;
    end
    oh = 3'b001 << idx;
    rd = s_rdat[32*idx +: 32];
    s = '{t0 + 1, oh, adr, wdat, we, sel};
    sq.push_back(s);
    case (kind)
      K_ACK, K_ERR, K_BOTH: begin
        if (kind == K_ACK) begin
          if (!we) exp_rdat = rd;
        end else begin
          exp_eaddr = adr;
          exp_ecnt  = ref_inc(exp_ecnt);
        end
        r = '{t0 + k + 1, kind != K_ACK, exp_rdat, exp_eaddr, exp_ecnt};
        rq.push_back(r);
        for (int c = 1; c <= k; c++) begin
          @(posedge clk); #1;
          drive_noise(oh, noise);
          if (c == k) begin
            s_ack[idx] = (kind != K_ERR);
            s_err[idx] = (kind != K_ACK);
          end
        end
        @(posedge clk); #1;
        s_ack = '0; s_err = '0;
        wait_resp();
        end_req();
      end
      K_ABORT: begin
        for (int c = 1; c <= k; c++) begin
          @(posedge clk); #1;
          drive_noise(oh, noise);
        end
        m_cyc = 1'b0; m_stb = 1'b0;
        s_ack = '0; s_err = '0;
        @(posedge clk); #1;
        chk("abort_s_cyc", 32'(s_cyc), 32'd0);
        chk("abort_s_stb", 32'(s_stb), 32'd0);
        @(posedge clk); #1;
      end
      K_RST: begin
        for (int c = 1; c <= k; c++) begin
          @(posedge clk); #1;
          drive_noise(oh, noise);
        end
        #1 arstn = 1'b0;
        #1;
        chk("rst_s_cyc_stb", {26'd0, s_cyc, s_stb}, 32'd0);
        chk("rst_m_ack_err", {30'd0, m_ack, m_err}, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_m_rdat", m_rdat, 32'd0);
        exp_rdat = '0; exp_eaddr = '0; exp_ecnt = '0;
        m_cyc = 1'b0; m_stb = 1'b0;
        s_ack = '0; s_err = '0;
        #1 arstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_s_cyc", 32'(s_cyc), 32'd0);
        @(posedge clk); #1;
      end
      default: begin
`ifdef WB_IC_TIMEOUT_EN
        exp_eaddr = adr;
        exp_ecnt  = ref_inc(exp_ecnt);
        r = '{t0 + TO + 1, 1'b1, exp_rdat, exp_eaddr, exp_ecnt};
        rq.push_back(r);
        wait_resp();
        end_req();
`else
        repeat (TO + 3) begin
          @(posedge clk); #1;
          drive_noise(oh, noise);
        end
        chk("hang_still_strobed", 32'(s_stb), 32'(oh));
        m_cyc = 1'b0; m_stb = 1'b0;
        s_ack = '0; s_err = '0;
        @(posedge clk); #1;
        chk("hang_abort_s_cyc", 32'(s_cyc), 32'd0);
        @(posedge clk); #1;
`endif
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int k;
    logic [31:0] adr;
    arstn = 1'b0;
    m_adr = '0; m_wdat = '0; m_we = 1'b0; m_sel = '0; m_stb = 1'b0; m_cyc = 1'b0;
    s_rdat = '0; s_ack = '0; s_err = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_outputs", {m_rdat[31:2], m_ack, m_err}, 32'd0);
    chk("reset_m_rdat", m_rdat, 32'd0);
    chk("reset_s_strobes", {26'd0, s_stb, s_cyc}, 32'd0);
    chk("reset_s_adr", s_adr, 32'd0);
    chk("reset_s_wdat", s_wdat, 32'd0);
    chk("reset_s_we_sel", {27'd0, s_we, s_sel}, 32'd0);
    chk("reset_err", {err_addr[23:0], err_count}, 32'd0);
    arstn = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    s_rdat = {32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_0000};
    do_txn(32'h9000_1004, 1'b0, 32'h0, 4'hF, K_ACK, 1, 1'b0);
    do_txn(32'h9000_2010, 1'b1, 32'h1234_5678, 4'b0011, K_ACK, 2, 1'b0);
    do_txn(32'h8000_0000, 1'b0, 32'h0, 4'hF, K_ACK, 1, 1'b0);
    s_rdat = {32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
    do_txn(32'h9000_0040, 1'b0, 32'h0, 4'hF, K_BOTH, 2, 1'b0);
    do_txn(32'h9000_0100, 1'b0, 32'h0, 4'hF, K_ACK, 3, 1'b1);
    do_txn(32'h9000_0200, 1'b0, 32'h0, 4'hF, K_ACK, TO, 1'b0);
    do_txn(32'h9000_0300, 1'b0, 32'h0, 4'hF, K_ERR, 1, 1'b1);
    do_txn(32'h9000_0400, 1'b1, 32'hAAAA_5555, 4'hF, K_ABORT, 2, 1'b0);
    do_txn(32'h9000_1400, 1'b0, 32'h0, 4'hF, K_RST, 2, 1'b0);
    do_txn(32'h9000_1404, 1'b0, 32'h0, 4'hF, K_ACK, 1, 1'b0);
    do_txn(32'h9000_0008, 1'b0, 32'h0, 4'hF, K_HANG, 1, 1'b1);
    do_txn(32'h9000_3000, 1'b0, 32'h0, 4'h1, K_ACK, 1, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 150; n++) begin
      s_rdat = {$urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 9) < 7) adr = {16'h9000, 16'($urandom_range(0, 16'h7FFF))};
      else                          adr = $urandom();
      kind = $urandom_range(0, 9);
      if (kind > K_HANG) kind = K_ACK;
      k = (kind == K_RST) ? $urandom_range(2, 4) : $urandom_range(1, 4);
      do_txn(adr, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)),
             kind, k, 1'($urandom_range(0, 1)));
    end

    // Push the error counter into saturation
    for (int n = 0; n < 260; n++) begin
      do_txn(32'h7000_0000 + 32'(n), 1'b0, 32'h0, 4'hF, K_ACK, 1, 1'b0);
    end
    chk("err_count_saturated", 32'(err_count), 32'hFF);

    repeat (5) @(posedge clk);
    #1;
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("stb_queue_drained", 32'(sq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_interconnect.md
WB_INTERCONNECT -- requirements
Module: wb_interconnect

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 3, giving the number of Wishbone slave ports (1..8).
REQ-002 SHALL have parameter SLV_BASE, default {32'h9000_2000, 32'h9000_1000, 32'h9000_0000}, holding packed base addresses with slave i at bits [32i+31:32i].
REQ-003 SHALL have parameter SLV_MASK, default {3{32'hFFFF_F000}}, holding packed per-slave address masks.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the slave wait limit (2..65535).
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
- clk  in  1  system clock
- arstn  in  1  asynchronous active-low reset
- m_adr  in  32  master address
- m_wdat  in  32  master write data
- m_we  in  1  master write enable
- m_sel  in  4  master byte select
- m_stb, m_cyc  in  1  master strobe and cycle
- m_rdat  out  32  read data to master
- m_ack, m_err  out  1  master acknowledge and error
- s_adr, s_wdat  out  32  latched address and write data, shared by all slaves
- s_we  out  1  latched write enable, shared
- s_sel  out  4  latched byte select, shared
- s_stb, s_cyc  out  NUM_SLAVES  per-slave strobe and cycle
- s_rdat  in  32*NUM_SLAVES  packed slave read data
- s_ack, s_err  in  NUM_SLAVES  per-slave acknowledge and error
- err_addr  out  32  address of the most recent errored access
- err_count  out  8  saturating error counter

Function
REQ-006 SHALL decode slave i when (m_adr & SLV_MASK_i) == SLV_BASE_i; if several slaves match, the lowest index SHALL win.
REQ-007 SHALL implement FSM IDLE, ACTIVE, RESP.
REQ-008 In IDLE with m_cyc&m_stb and a decode hit, SHALL latch adr/wdat/we/sel and the slave index, and go to ACTIVE.
REQ-009 In IDLE with m_cyc&m_stb and no decode hit, SHALL latch err_addr=m_adr and go to RESP with error flag set; no slave is strobed.
REQ-010 In ACTIVE, SHALL drive s_cyc[i]=s_stb[i]=1 only for the selected slave, with all other bits 0.
REQ-011 In ACTIVE, SHALL ignore s_ack/s_err from non-selected slaves.
REQ-012 In ACTIVE, selected s_err SHALL go to RESP with error.
REQ-013 In ACTIVE, selected s_ack without s_err SHALL register s_rdat of that slave into m_rdat and go to RESP with ack.
REQ-014 If selected s_ack and s_err are high in the same cycle, error SHALL win.
REQ-015 In RESP, SHALL pulse exactly one of m_ack/m_err for one cycle, deassert all s_stb/s_cyc, and return to IDLE.
REQ-016 Master request signals SHALL be sampled only in IDLE, so back-to-back transfers have one idle cycle between them.
REQ-017 Latency: request seen in cycle 0, slave strobe in cycle 1, slave ack in cycle k, m_ack in cycle k+1; minimum request-to-ack is 2 cycles.
REQ-018 If m_cyc drops in ACTIVE, SHALL deassert the slave strobe next cycle and return to IDLE with no m_ack/m_err.
REQ-019 Every error SHALL latch err_addr and increment err_count, which saturates at 8'hFF.
REQ-020 m_rdat SHALL hold its last value except on an acked read.

Reset
REQ-021 While arstn=0, outputs SHALL asynchronously clear to 0, the FSM SHALL be IDLE, and the timeout counter SHALL be 0.
REQ-022 Reset mid-transaction SHALL abort the transfer with no response after release.

Configuration
REQ-023 With macro WB_IC_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entering ACTIVE and increment each ACTIVE cycle.
REQ-024 With WB_IC_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without ack/err SHALL go to RESP with error.
REQ-025 With WB_IC_TIMEOUT_EN defined, an ack in the timeout cycle SHALL win over the timeout.
REQ-026 Without WB_IC_TIMEOUT_EN, ACTIVE SHALL wait indefinitely, TIMEOUT_CYCLES SHALL be ignored, and no counter logic SHALL exist.

Verification
REQ-027 Read 0x9000_1004; slave 1 acks in cycle 1 with 0xDEAD_BEEF -> s_stb=3'b010, m_rdat=0xDEAD_BEEF, m_ack in cycle 2.
REQ-028 Write 0x9000_2010 data 0x1234_5678 sel 4'b0011 -> slave 2 sees the same s_wdat/s_sel/s_we=1; one m_ack.
REQ-029 Access 0x8000_0000 -> no s_stb, m_err in cycle 1, err_addr=0x8000_0000, err_count=1.
REQ-030 With WB_IC_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave 0 never acks -> m_err 5 cycles after request, s_stb cleared.
REQ-031 Slave 0 asserts s_ack and s_err together -> m_err only; slave 1 acks while slave 0 is selected -> ignored.
REQ-032 Drop m_cyc in ACTIVE, or pulse arstn low mid-transfer -> no m_ack/m_err, all s_cyc=0, next access works normally.
